// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register write-reservation scoreboard.
package reg_scoreboard_pkg;

    localparam int NUM_REGS       = 32;
    localparam int ADDR_WIDTH     = 5;
    localparam int CNT_WIDTH      = 2;
    localparam int INFLIGHT_WIDTH = ADDR_WIDTH + CNT_WIDTH;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/binary_to_onehot_32bit.sv
// 5-bit binary index to 32-bit one-hot decoder.
module binary_to_onehot_32bit (
    input  logic [4:0]  i_bin,
    output logic [31:0] o_onehot
);

    assign o_onehot = 32'd1 << i_bin;

endmodule

// File: rtl/scoreboard_counter.sv
// Saturating pending-write counter for one architectural register.
module scoreboard_counter
    import reg_scoreboard_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic inc,
    input  logic dec_wb,
    input  logic dec_kill,
    output cnt_t count,
    output logic busy,
    output logic err
);

    typedef logic signed [CNT_WIDTH+1:0] sum_t;

    localparam sum_t SUM_MAX = sum_t'({2'b00, CNT_MAX});

    sum_t next_sum;

    function automatic cnt_t clamp_cnt(input sum_t v);
        if (v < 0) begin
            return '0;
        end else if (v > SUM_MAX) begin
            return CNT_MAX;
        end else begin
            return v[CNT_WIDTH-1:0];
        end
    endfunction

    // Two extra bits hold the -2..max+1 range of count + inc - dec_wb - dec_kill.
    assign next_sum = sum_t'({2'b00, count})
                    + sum_t'({{(CNT_WIDTH+1){1'b0}}, inc})
                    - sum_t'({{(CNT_WIDTH+1){1'b0}}, dec_wb})
                    - sum_t'({{(CNT_WIDTH+1){1'b0}}, dec_kill});

    assign err  = (next_sum < 0) || (next_sum > SUM_MAX);
    assign busy = |count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else begin
            count <= clamp_cnt(next_sum);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Write-reservation scoreboard: reserves rd at issue, releases on writeback
// or squash, and stalls decode on any source with an outstanding write.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_issue_valid,
    input  logic [ADDR_WIDTH-1:0]     i_issue_rd_addr,
    input  logic                      i_issue_rd_wren,
    input  logic [ADDR_WIDTH-1:0]     i_issue_rs1_addr,
    input  logic                      i_issue_rs1_used,
    input  logic [ADDR_WIDTH-1:0]     i_issue_rs2_addr,
    input  logic                      i_issue_rs2_used,
    output logic                      o_issue_stall,
    output logic                      o_issue_fire,
    input  logic                      i_wb_valid,
    input  logic [ADDR_WIDTH-1:0]     i_wb_rd_addr,
    input  logic                      i_wb_rd_wren,
    input  logic                      i_kill_valid,
    input  logic [ADDR_WIDTH-1:0]     i_kill_rd_addr,
    input  logic                      i_kill_rd_wren,
    output logic [NUM_REGS-1:0]       o_busy_vec,
    output logic [INFLIGHT_WIDTH-1:0] o_inflight,
    output logic                      o_error
);

    logic [31:0] inc_oh;
    logic [31:0] wb_oh;
    logic [31:0] kill_oh;

    logic [NUM_REGS-1:0][CNT_WIDTH-1:0] count_vec;
    logic [NUM_REGS-1:0]                busy;
    logic [NUM_REGS-1:0]                err_vec;

    logic inc_en;
    logic wb_en;
    logic kill_en;
    logic haz;
    logic sat;
    logic error_q;
    logic unused_oh0;

    binary_to_onehot_32bit u_inc_dec (
        .i_bin    (i_issue_rd_addr),
        .o_onehot (inc_oh)
    );

    binary_to_onehot_32bit u_wb_dec (
        .i_bin    (i_wb_rd_addr),
        .o_onehot (wb_oh)
    );

    binary_to_onehot_32bit u_kill_dec (
        .i_bin    (i_kill_rd_addr),
        .o_onehot (kill_oh)
    );

    // x0 has no counter: it reads as permanently free and never errors.
    assign count_vec[0] = '0;
    assign busy[0]      = 1'b0;
    assign err_vec[0]   = 1'b0;
    assign unused_oh0   = ^{inc_oh[0], wb_oh[0], kill_oh[0]};

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_cnt
            scoreboard_counter u_cnt (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .inc      (inc_en & inc_oh[r]),
                .dec_wb   (wb_en & wb_oh[r]),
                .dec_kill (kill_en & kill_oh[r]),
                .count    (count_vec[r]),
                .busy     (busy[r]),
                .err      (err_vec[r])
            );
        end
    endgenerate

    assign haz = (i_issue_rs1_used && (i_issue_rs1_addr != '0) && (count_vec[i_issue_rs1_addr] != '0))
              || (i_issue_rs2_used && (i_issue_rs2_addr != '0) && (count_vec[i_issue_rs2_addr] != '0));
    assign sat = i_issue_rd_wren && (i_issue_rd_addr != '0) && (count_vec[i_issue_rd_addr] == CNT_MAX);

    assign o_issue_stall = i_issue_valid & (haz | sat);
    assign o_issue_fire  = i_issue_valid & ~o_issue_stall;

    assign inc_en  = o_issue_fire & i_issue_rd_wren;
    assign wb_en   = i_wb_valid & i_wb_rd_wren;
    assign kill_en = i_kill_valid & i_kill_rd_wren;

    always_comb begin
        o_inflight = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            o_inflight = o_inflight + {{ADDR_WIDTH{1'b0}}, count_vec[i]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_q | (|err_vec);
        end
    end

    assign o_busy_vec = busy;
    assign o_error    = error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard against a per-register counting model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic                      i_clk;
    logic                      i_reset;
    logic                      i_issue_valid;
    logic [ADDR_WIDTH-1:0]     i_issue_rd_addr;
    logic                      i_issue_rd_wren;
    logic [ADDR_WIDTH-1:0]     i_issue_rs1_addr;
    logic                      i_issue_rs1_used;
    logic [ADDR_WIDTH-1:0]     i_issue_rs2_addr;
    logic                      i_issue_rs2_used;
    logic                      o_issue_stall;
    logic                      o_issue_fire;
    logic                      i_wb_valid;
    logic [ADDR_WIDTH-1:0]     i_wb_rd_addr;
    logic                      i_wb_rd_wren;
    logic                      i_kill_valid;
    logic [ADDR_WIDTH-1:0]     i_kill_rd_addr;
    logic                      i_kill_rd_wren;
    logic [NUM_REGS-1:0]       o_busy_vec;
    logic [INFLIGHT_WIDTH-1:0] o_inflight;
    logic                      o_error;

    reg_scoreboard dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_issue_valid    (i_issue_valid),
        .i_issue_rd_addr  (i_issue_rd_addr),
        .i_issue_rd_wren  (i_issue_rd_wren),
        .i_issue_rs1_addr (i_issue_rs1_addr),
        .i_issue_rs1_used (i_issue_rs1_used),
        .i_issue_rs2_addr (i_issue_rs2_addr),
        .i_issue_rs2_used (i_issue_rs2_used),
        .o_issue_stall    (o_issue_stall),
        .o_issue_fire     (o_issue_fire),
        .i_wb_valid       (i_wb_valid),
        .i_wb_rd_addr     (i_wb_rd_addr),
        .i_wb_rd_wren     (i_wb_rd_wren),
        .i_kill_valid     (i_kill_valid),
        .i_kill_rd_addr   (i_kill_rd_addr),
        .i_kill_rd_wren   (i_kill_rd_wren),
        .o_busy_vec       (o_busy_vec),
        .o_inflight       (o_inflight),
        .o_error          (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending-write count per register plus a sticky error bit.
    localparam int MAXC = (1 << CNT_WIDTH) - 1;
    int   m_cnt [NUM_REGS];
    bit   m_err;
    logic e_stall, e_fire;
    logic [NUM_REGS-1:0] e_busy;
    int   e_infl;

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
        m_err = 1'b0;
    endtask

    task automatic model_eval();
        bit haz, sat;
        haz = (i_issue_rs1_used && i_issue_rs1_addr != 0 && m_cnt[i_issue_rs1_addr] > 0) ||
              (i_issue_rs2_used && i_issue_rs2_addr != 0 && m_cnt[i_issue_rs2_addr] > 0);
        sat = i_issue_rd_wren && i_issue_rd_addr != 0 && m_cnt[i_issue_rd_addr] == MAXC;
        e_stall = i_issue_valid && (haz || sat);
        e_fire  = i_issue_valid && !e_stall;
        e_infl  = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            e_busy[r] = (m_cnt[r] != 0);
            e_infl += m_cnt[r];
        end
    endtask

    task automatic model_update();
        int n;
        for (int r = 1; r < NUM_REGS; r++) begin
            n = m_cnt[r];
            if (e_fire && i_issue_rd_wren && i_issue_rd_addr == r) n++;
            if (i_wb_valid && i_wb_rd_wren && i_wb_rd_addr == r) n--;
            if (i_kill_valid && i_kill_rd_wren && i_kill_rd_addr == r) n--;
            if (n < 0)    begin n = 0;    m_err = 1'b1; end
            if (n > MAXC) begin n = MAXC; m_err = 1'b1; end
            m_cnt[r] = n;
        end
    endtask

    // Advance one clock: evaluate model on pre-edge state, update it at the edge.
    task automatic step();
        model_eval();
        @(posedge i_clk);
        if (i_reset) model_update();
        else model_reset();
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_issue_valid = 0; i_issue_rd_addr = 0; i_issue_rd_wren = 0;
        i_issue_rs1_addr = 0; i_issue_rs1_used = 0; i_issue_rs2_addr = 0; i_issue_rs2_used = 0;
        i_wb_valid = 0; i_wb_rd_addr = 0; i_wb_rd_wren = 0;
        i_kill_valid = 0; i_kill_rd_addr = 0; i_kill_rd_wren = 0;
    endtask

    task automatic issue(input int rd, input bit wren, input int rs1, input bit u1, input int rs2, input bit u2);
        i_issue_valid = 1; i_issue_rd_addr = rd[ADDR_WIDTH-1:0]; i_issue_rd_wren = wren;
        i_issue_rs1_addr = rs1[ADDR_WIDTH-1:0]; i_issue_rs1_used = u1;
        i_issue_rs2_addr = rs2[ADDR_WIDTH-1:0]; i_issue_rs2_used = u2;
    endtask

    task automatic wb(input bit v, input int rd);
        i_wb_valid = v; i_wb_rd_addr = rd[ADDR_WIDTH-1:0]; i_wb_rd_wren = v;
    endtask

    task automatic kill(input bit v, input int rd);
        i_kill_valid = v; i_kill_rd_addr = rd[ADDR_WIDTH-1:0]; i_kill_rd_wren = v;
    endtask

    task automatic test_reset();
        idle();
        i_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        issue(5, 1, 6, 1, 7, 1);
        #1;
        checks++; if (o_busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %h want 0", o_busy_vec); end
        checks++; if (o_inflight !== '0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", o_inflight); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", o_error); end
        checks++; if (o_issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", o_issue_stall); end
        idle();
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    task automatic test_raw_hazard();
        idle(); issue(5, 1, 0, 0, 0, 0); #1;
        checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL raw_first_fire: got %b want 1", o_issue_fire); end
        step();
        issue(1, 0, 5, 1, 0, 0); #1;
        checks++; if (o_issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", o_issue_stall); end
        checks++; if (o_busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy5: got %b want 1", o_busy_vec[5]); end
        checks++; if (o_inflight !== 7'd1) begin errors++; $display("FAIL raw_inflight: got %0d want 1", o_inflight); end
        step();
        wb(1, 5); #1;
        checks++; if (o_issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_during_wb: got %b want 1", o_issue_stall); end
        step();
        wb(0, 0); #1;
        checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL raw_fire_after_wb: got %b want 1", o_issue_fire); end
        checks++; if (o_inflight !== 7'd0) begin errors++; $display("FAIL raw_inflight_after_wb: got %0d want 0", o_inflight); end
        step();
        idle();
    endtask

    task automatic test_saturation();
        idle();
        for (int k = 0; k < 3; k++) begin
            issue(7, 1, 0, 0, 0, 0); #1;
            checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL sat_fire_%0d: got %b want 1", k, o_issue_fire); end
            step();
            checks++; if (o_inflight !== 7'(k + 1)) begin errors++; $display("FAIL sat_count_%0d: got %0d want %0d", k, o_inflight, k + 1); end
        end
        #1;
        checks++; if (o_issue_stall !== 1'b1 || o_issue_fire !== 1'b0) begin
            errors++; $display("FAIL sat_fourth: got stall=%b fire=%b want stall=1 fire=0", o_issue_stall, o_issue_fire); end
        step();
        wb(1, 7); #1;
        checks++; if (o_issue_stall !== 1'b1) begin errors++; $display("FAIL sat_stall_with_wb: got %b want 1", o_issue_stall); end
        step();
        wb(0, 0); #1;
        checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL sat_fire_after_wb: got %b want 1", o_issue_fire); end
        step();
        idle();
        wb(1, 7);
        repeat (3) step();
        idle(); #1;
        checks++; if (o_inflight !== 7'd0 || o_error !== 1'b0) begin
            errors++; $display("FAIL sat_drain: got inflight=%0d err=%b want 0 0", o_inflight, o_error); end
    endtask

    task automatic test_x0();
        idle(); issue(0, 1, 0, 0, 0, 0); #1;
        checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL x0_fire: got %b want 1", o_issue_fire); end
        step();
        issue(0, 1, 0, 1, 0, 1); #1;
        checks++; if (o_issue_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", o_issue_stall); end
        checks++; if (o_busy_vec !== '0 || o_inflight !== '0) begin
            errors++; $display("FAIL x0_state: got busy=%h inflight=%0d want 0 0", o_busy_vec, o_inflight); end
        step();
        idle();
    endtask

    task automatic test_same_cycle();
        idle(); issue(9, 1, 0, 0, 0, 0);
        step();
        wb(1, 9); #1;
        checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL same_fire_wb: got %b want 1", o_issue_fire); end
        step();
        checks++; if (o_inflight !== 7'd1 || o_busy_vec[9] !== 1'b1) begin
            errors++; $display("FAIL same_inc_dec: got inflight=%0d busy9=%b want 1 1", o_inflight, o_busy_vec[9]); end
        kill(1, 9); #1;
        checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL same_fire_wb_kill: got %b want 1", o_issue_fire); end
        step();
        idle(); #1;
        checks++; if (o_inflight !== 7'd0 || o_busy_vec[9] !== 1'b0 || o_error !== 1'b0) begin
            errors++; $display("FAIL same_triple: got inflight=%0d busy9=%b err=%b want 0 0 0", o_inflight, o_busy_vec[9], o_error); end
    endtask

    task automatic test_underflow();
        idle(); wb(1, 12);
        step();
        idle(); #1;
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL uflow_error: got %b want 1", o_error); end
        checks++; if (o_busy_vec[12] !== 1'b0 || o_inflight !== 7'd0) begin
            errors++; $display("FAIL uflow_clamp: got busy12=%b inflight=%0d want 0 0", o_busy_vec[12], o_inflight); end
        repeat (3) step();
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL uflow_sticky: got %b want 1", o_error); end
    endtask

    task automatic test_async_reset();
        idle();
        issue(3, 1, 0, 0, 0, 0); step();
        step();
        issue(4, 1, 0, 0, 0, 0); step();
        idle(); #1;
        checks++; if (o_inflight !== 7'd3 || o_error !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got inflight=%0d err=%b want 3 1", o_inflight, o_error); end
        #1 i_reset = 1'b0;
        #1;
        checks++; if (o_busy_vec !== '0 || o_inflight !== '0 || o_error !== 1'b0) begin
            errors++; $display("FAIL areset_immediate: got busy=%h inflight=%0d err=%b want 0 0 0", o_busy_vec, o_inflight, o_error); end
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 400; it++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                issue($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(1, 7);
                wb(1, (m_cnt[r] > 0 || $urandom_range(0, 7) == 0) ? r : 0);
            end
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(1, 7);
                kill(1, (m_cnt[r] > 0 || $urandom_range(0, 7) == 0) ? r : 0);
            end
            #1;
            model_eval();
            checks++; if (o_issue_stall !== e_stall || o_issue_fire !== e_fire) begin
                errors++; $display("FAIL rand_decision it=%0d: got stall=%b fire=%b want stall=%b fire=%b",
                                   it, o_issue_stall, o_issue_fire, e_stall, e_fire); end
            checks++; if (o_busy_vec !== e_busy || o_inflight !== e_infl[INFLIGHT_WIDTH-1:0] || o_error !== m_err) begin
                errors++; $display("FAIL rand_state it=%0d: got busy=%h infl=%0d err=%b want busy=%h infl=%0d err=%b",
                                   it, o_busy_vec, o_inflight, o_error, e_busy, e_infl, m_err); end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw_hazard();
        test_saturation();
        test_x0();
        test_same_cycle();
        test_underflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Write-reservation tracker paired with the register file in the non-forwarding pipeline.
- Decode reserves the destination register at issue. Writeback, or a squash of that instruction, releases the reservation.
- A source read of a register with any outstanding write stalls decode.
- Owns the write side of register-file coherence; the register file itself only stores data.

Parameters:
- NUM_REGS, 32, number of architectural registers (x0 hardwired zero).
- ADDR_WIDTH, 5, register address width (log2 NUM_REGS).
- CNT_WIDTH, 2, per-register pending-write counter width; max in-flight writes per register = 2^CNT_WIDTH-1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_issue_valid  in  1  decode presents an instruction.
- i_issue_rd_addr  in  ADDR_WIDTH  destination of the decoded instruction.
- i_issue_rd_wren  in  1  decoded instruction writes rd.
- i_issue_rs1_addr  in  ADDR_WIDTH  source 1 address.
- i_issue_rs1_used  in  1  source 1 is read.
- i_issue_rs2_addr  in  ADDR_WIDTH  source 2 address.
- i_issue_rs2_used  in  1  source 2 is read.
- o_issue_stall  out  1  decode must hold; instruction not accepted.
- o_issue_fire  out  1  instruction accepted this cycle.
- i_wb_valid  in  1  writeback stage retiring an instruction.
- i_wb_rd_addr  in  ADDR_WIDTH  writeback destination.
- i_wb_rd_wren  in  1  retiring instruction wrote rd.
- i_kill_valid  in  1  an issued instruction was squashed.
- i_kill_rd_addr  in  ADDR_WIDTH  squashed instruction's rd.
- i_kill_rd_wren  in  1  squashed instruction held a reservation.
- o_busy_vec  out  NUM_REGS  bit r = 1 when count[r] != 0; bit 0 always 0.
- o_inflight  out  ADDR_WIDTH+CNT_WIDTH  sum of all counters.
- o_error  out  1  sticky underflow/overflow flag.

Behaviour:
- State: count[1..NUM_REGS-1], each CNT_WIDTH bits; o_error register. There is no count[0].
- Reset (i_reset=0, asynchronous): all counters 0, o_error 0. Consequently o_busy_vec=0, o_inflight=0, o_issue_stall=0.
- Hazard term: haz = (rs1_used & rs1!=0 & count[rs1]!=0) | (rs2_used & rs2!=0 & count[rs2]!=0).
- Saturation term: sat = rd_wren & rd!=0 & count[rd]==max.
- o_issue_stall = i_issue_valid & (haz | sat). Combinational from registered counters only.
- o_issue_fire = i_issue_valid & ~o_issue_stall.
- Zero-latency evaluation: a decision reflects reservations made up to and including the previous edge.
- The register file has no write-through. A writeback in cycle N to a register read in cycle N still stalls in cycle N. The read proceeds in N+1.
- Increment: on fire with rd_wren & rd!=0, inc[rd]=1.
- Decrement (writeback): wb_valid & wb_wren & addr!=0 gives dec_wb[addr]=1.
- Decrement (kill): kill_valid & kill_wren & addr!=0 gives dec_kill[addr]=1.
- Update per register each edge: count += inc - dec_wb - dec_kill. Net delta is in -2..+1; all three may hit the same register in one cycle.
- Underflow: a decrement exceeding the current count clamps the result at 0 and sets o_error.
- Overflow: unreachable through the port, since sat blocks issue. The increment path still clamps at max and sets o_error if it ever triggers.
- o_error clears only on reset.
- Address 0 in any role: no reservation, never stalls, never errors.
- Self-dependence (rd == rs1 with the reg free): no stall; the reservation is taken at fire.
- o_inflight: combinational sum of counters.
- Reset mid-operation: all reservations are dropped immediately. The pipeline is flushed by the same reset.

Decomposition:
- Shared package: ADDR_WIDTH and NUM_REGS constants, CNT_WIDTH, and the cnt_t typedef.
- Reuse binary_to_onehot_32bit for the inc, dec_wb and dec_kill decode vectors.
- One natural sub-module: scoreboard_counter. It is a single saturating up/down counter taking inc, dec_wb and dec_kill, producing count, busy and err. It is instantiated NUM_REGS-1 times in a generate loop.

Test Plan:
1. Reset release, issue rd=5 wren=1 fire. Next cycle issue rs1=5 used -> stall=1, busy_vec[5]=1, inflight=1. Then wb rd=5 -> stall stays 1 that cycle, fire=1 the following cycle.
2. Issue rd=7 three times back-to-back (rs unused) -> counts 1,2,3. The fourth issue rd=7 gives stall=1 (sat) and fire=0. One wb rd=7 -> the next issue fires.
3. Issue rd=0 wren=1, then rs1=0 rs2=0 used -> never stall, busy_vec=0, inflight=0.
4. count[9]=1, same cycle: fire rd=9 plus wb rd=9 -> count[9]=1. Next cycle fire rd=9 plus wb rd=9 plus kill rd=9 -> count[9]=0, o_error=0.
5. wb rd=12 with count[12]=0 -> count stays 0, o_error=1 and stays 1 until reset.
6. Counts at x3=2 and x4=1, assert i_reset low mid-cycle -> busy_vec=0, inflight=0 and o_error=0 immediately (asynchronous), before the next clock edge.
